// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller with a multiply/divide unit sequencer.
// Produces combinational stall/flush controls for the F/D/E pipeline
// registers, sequences MDU latency (IDLE -> BUSY -> DONE), and keeps a
// saturating count of stalled cycles.
module pipe_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        branch_d,
    input  logic        pc_src_d,
    input  logic        hilo_rd_d,
    input  logic        md_op_d,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic [4:0]  write_reg_e,
    input  logic        mem_to_reg_m,
    input  logic [4:0]  write_reg_m,
    input  logic        md_start_e,
    input  logic        md_div_e,
    input  logic        md_abort,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        flush_d,
    output logic        md_busy,
    output logic        hilo_we,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Counter preload is latency minus one so BUSY spans exactly LAT cycles.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_t   state_r;
    md_state_t   state_nxt_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nxt_s;
    logic        hilo_we_s;
    logic        md_busy_s;
    logic        lu_stall_s;
    logic        br_stall_s;
    logic        md_stall_s;
    logic        stall_s;
    logic [15:0] stall_cycles_r;

    // A destination matches a source only when it is a real register (not r0).
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src_a,
                                       input logic [4:0] src_b);
        return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
    endfunction

    // Hazard detection: load-use, branch operand, and MDU result hazards.
    always_comb begin
        lu_stall_s = mem_to_reg_e & reg_match(write_reg_e, rs_d, rt_d);
        br_stall_s = branch_d &
                     ((reg_write_e  & reg_match(write_reg_e, rs_d, rt_d)) |
                      (mem_to_reg_m & reg_match(write_reg_m, rs_d, rt_d)));
        md_stall_s = md_busy_s & (hilo_rd_d | md_op_d);
        stall_s    = lu_stall_s | br_stall_s | md_stall_s;
    end

    // MDU sequencer next state, counter and HI/LO write strobe.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hilo_we_s   = 1'b0;
        md_busy_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (md_abort) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 6'd0;
                end else if (md_start_e) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = md_div_e ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                md_busy_s = 1'b1;
                if (md_abort) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 6'd0;
                end else if (cnt_r == 6'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 6'd1;
                end
            end
            ST_DONE: begin
                md_busy_s = 1'b1;
                if (md_abort) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 6'd0;
                end else if (md_start_e) begin
                    hilo_we_s   = 1'b1;
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = md_div_e ? DIV_LOAD : MUL_LOAD;
                end else begin
                    hilo_we_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

    // MDU state and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Saturating stalled-cycle counter; one count per stalled edge at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 16'd0;
        end else if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_f      = stall_s;
    assign stall_d      = stall_s;
    assign flush_e      = stall_s;
    assign flush_d      = pc_src_d & ~stall_s;
    assign md_busy      = md_busy_s;
    assign hilo_we      = hilo_we_s;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard vector table, hand-written MDU
// sequences, randomized traffic against a reference model, and saturation.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_d, rt_d;
    logic        branch_d, pc_src_d, hilo_rd_d, md_op_d;
    logic        reg_write_e, mem_to_reg_e;
    logic [4:0]  write_reg_e;
    logic        mem_to_reg_m;
    logic [4:0]  write_reg_m;
    logic        md_start_e, md_div_e, md_abort;
    logic        stall_f, stall_d, flush_e, flush_d, md_busy, hilo_we;
    logic [15:0] stall_cycles;

    int n_cmp;
    int n_bad;

    // Reference model: m_e = cycles elapsed since the op started (0 = no op),
    // m_l = op latency; BUSY while 1..m_l, result cycle at m_l+1.
    int m_e;
    int m_l;
    int m_sc;

    pipe_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
        .branch_d(branch_d), .pc_src_d(pc_src_d),
        .hilo_rd_d(hilo_rd_d), .md_op_d(md_op_d),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .write_reg_e(write_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .write_reg_m(write_reg_m), .md_start_e(md_start_e),
        .md_div_e(md_div_e), .md_abort(md_abort),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .flush_d(flush_d), .md_busy(md_busy), .hilo_we(hilo_we),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       br, pcs, mre, rwe;
        logic [4:0] wre;
        logic       mrm;
        logic [4:0] wrm;
        logic       e_stall, e_flush;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(int rs, int rt, int br, int pcs, int mre, int rwe,
                                int wre, int mrm, int wrm, int s, int f);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.br = 1'(br); v.pcs = 1'(pcs);
        v.mre = 1'(mre); v.rwe = 1'(rwe); v.wre = 5'(wre);
        v.mrm = 1'(mrm); v.wrm = 5'(wrm); v.e_stall = 1'(s); v.e_flush = 1'(f);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        rs_d = 5'd0; rt_d = 5'd0; branch_d = 1'b0; pc_src_d = 1'b0;
        hilo_rd_d = 1'b0; md_op_d = 1'b0; reg_write_e = 1'b0;
        mem_to_reg_e = 1'b0; write_reg_e = 5'd0; mem_to_reg_m = 1'b0;
        write_reg_m = 5'd0; md_start_e = 1'b0; md_div_e = 1'b0; md_abort = 1'b0;
    endtask

    function automatic bit hits(input logic [4:0] dst);
        return (dst != 5'd0) && (dst == rs_d || dst == rt_d);
    endfunction

    // Check every output against the model, clock once, advance the model.
    task automatic cycle();
        bit busy_x, we_x, st;
        #1;
        busy_x = (m_e != 0);
        we_x   = (m_e == m_l + 1) && !md_abort;
        st = (mem_to_reg_e && hits(write_reg_e)) ||
             (branch_d && ((reg_write_e && hits(write_reg_e)) ||
                           (mem_to_reg_m && hits(write_reg_m)))) ||
             (busy_x && (hilo_rd_d || md_op_d));
        chk("m_stall_f", stall_f, st);
        chk("m_stall_d", stall_d, st);
        chk("m_flush_e", flush_e, st);
        chk("m_flush_d", flush_d, pc_src_d && !st);
        chk("m_md_busy", md_busy, busy_x);
        chk("m_hilo_we", hilo_we, we_x);
        chk("m_stall_cycles", stall_cycles, m_sc);
        @(posedge clk);
        if (st && m_sc < 65535) m_sc++;
        if (md_abort) begin
            m_e = 0;
        end else if (m_e == 0) begin
            if (md_start_e) begin m_e = 1; m_l = md_div_e ? 32 : 4; end
        end else if (m_e <= m_l) begin
            m_e++;
        end else begin
            if (md_start_e) begin m_e = 1; m_l = md_div_e ? 32 : 4; end
            else m_e = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        m_e = 0; m_l = 1; m_sc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_md(input string n, input bit b, input bit w, input bit s);
        #1;
        chk({n, " md_busy"}, md_busy, b);
        chk({n, " hilo_we"}, hilo_we, w);
        chk({n, " stall_d"}, stall_d, s);
    endtask

    // Hold the current inputs for n edges without per-cycle checks.
    task automatic run_quiet(input int n);
        repeat (n) @(posedge clk);
        m_sc = (m_sc + n > 65535) ? 65535 : m_sc + n;
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_sc;
        n_cmp = 0; n_bad = 0;
        clr();
        rst = 1'b1;
        m_e = 0; m_l = 1; m_sc = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Idle outputs after reset release.
        #1;
        chk("rst stall_f", stall_f, 0); chk("rst stall_d", stall_d, 0);
        chk("rst flush_e", flush_e, 0); chk("rst flush_d", flush_d, 0);
        chk("rst md_busy", md_busy, 0); chk("rst hilo_we", hilo_we, 0);
        chk("rst stall_cycles", stall_cycles, 0);

        // Hazard table: rs rt br pcs mre rwe wre mrm wrm | stall flush
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(5, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 6, 0, 0, 1, 0, 6, 0, 0, 1, 0);
        vecs[4]  = mk(4, 6, 0, 0, 1, 0, 5, 0, 0, 0, 0);
        vecs[5]  = mk(2, 7, 1, 1, 0, 1, 7, 0, 0, 1, 0);
        vecs[6]  = mk(2, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(2, 7, 0, 1, 0, 1, 7, 0, 0, 0, 1);
        vecs[8]  = mk(9, 3, 1, 0, 0, 0, 0, 1, 9, 1, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[10] = mk(9, 3, 1, 0, 0, 0, 0, 0, 9, 0, 0);
        vecs[11] = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        vecs[12] = mk(3, 3, 1, 1, 1, 1, 3, 1, 3, 1, 0);
        vecs[13] = mk(8, 4, 1, 0, 0, 1, 4, 0, 0, 1, 0);
        exp_sc = 0;
        for (int i = 0; i < 14; i++) begin
            rs_d = vecs[i].rs; rt_d = vecs[i].rt; branch_d = vecs[i].br;
            pc_src_d = vecs[i].pcs; mem_to_reg_e = vecs[i].mre;
            reg_write_e = vecs[i].rwe; write_reg_e = vecs[i].wre;
            mem_to_reg_m = vecs[i].mrm; write_reg_m = vecs[i].wrm;
            #1;
            chk($sformatf("tbl%0d stall_f", i), stall_f, vecs[i].e_stall);
            chk($sformatf("tbl%0d flush_e", i), flush_e, vecs[i].e_stall);
            chk($sformatf("tbl%0d flush_d", i), flush_d, vecs[i].e_flush);
            exp_sc += int'(vecs[i].e_stall);
            cycle();
            chk($sformatf("tbl%0d count", i), stall_cycles, exp_sc);
        end

        // Multiply with mfhi waiting in Decode.
        do_reset();
        hilo_rd_d = 1'b1; md_start_e = 1'b1; md_div_e = 1'b0;
        expect_md("mul c0", 0, 0, 0);
        cycle();
        md_start_e = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            expect_md($sformatf("mul c%0d", k), k <= 5, k == 5, k <= 5);
            cycle();
        end

        // Divide aborted at cycle 10 (start in the same cycle is overridden).
        do_reset();
        md_div_e = 1'b1; md_start_e = 1'b1;
        cycle();
        md_start_e = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            md_abort   = (k == 10);
            md_start_e = (k == 10);
            expect_md($sformatf("div c%0d", k), k <= 10, 0, 0);
            cycle();
        end
        clr();

        // Start ignored while busy; back-to-back start in the result cycle.
        do_reset();
        md_start_e = 1'b1;
        cycle();
        for (int k = 1; k <= 11; k++) begin
            md_start_e = (k == 2 || k == 5);
            md_div_e   = (k == 2);
            expect_md($sformatf("b2b c%0d", k), k <= 10, k == 5 || k == 10, 0);
            cycle();
        end
        clr();

        // Reset in the middle of a divide.
        do_reset();
        hilo_rd_d = 1'b1; md_div_e = 1'b1; md_start_e = 1'b1;
        cycle();
        md_start_e = 1'b0;
        cycle();
        cycle();
        #1;
        chk("mid pre busy", md_busy, 1);
        chk("mid pre count", stall_cycles, 2);
        rst = 1'b1;
        #1;
        chk("mid rst busy", md_busy, 0);
        chk("mid rst count", stall_cycles, 0);
        chk("mid rst stall", stall_d, 0);
        m_e = 0; m_sc = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk("post rst hilo_we", hilo_we, 0);
            cycle();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
            branch_d = ($urandom_range(0, 2) == 0); pc_src_d = ($urandom_range(0, 2) == 0);
            reg_write_e = ($urandom_range(0, 1) == 0); mem_to_reg_e = ($urandom_range(0, 3) == 0);
            mem_to_reg_m = ($urandom_range(0, 3) == 0);
            hilo_rd_d = ($urandom_range(0, 2) == 0); md_op_d = ($urandom_range(0, 3) == 0);
            md_start_e = ($urandom_range(0, 7) == 0); md_div_e = ($urandom_range(0, 1) == 0);
            md_abort = ($urandom_range(0, 63) == 0);
            cycle();
        end

        // Saturation of the stall counter under a held load-use hazard.
        do_reset();
        mem_to_reg_e = 1'b1; write_reg_e = 5'd5; rs_d = 5'd5;
        run_quiet(65534);
        chk("sat 65534", stall_cycles, 16'hFFFE);
        run_quiet(1);
        chk("sat 65535", stall_cycles, 16'hFFFF);
        run_quiet(5);
        chk("sat hold", stall_cycles, 16'hFFFF);
        cycle();
        chk("sat final", stall_cycles, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
